// File: rtl/spartan_pkg.sv
// Shared definitions for the Spartan-bus to AXI3 endpoint: word tags, header layout, FSM states.
package spartan_pkg;

    localparam logic [1:0] REQ_RD    = 2'b00;
    localparam logic [1:0] REQ_WR    = 2'b01;
    localparam logic [1:0] DAT       = 2'b10;
    localparam logic [1:0] DAT_LAST  = 2'b11;
    localparam logic [1:0] RSP_WR    = 2'b00;
    localparam logic [1:0] RSP_RDHDR = 2'b01;

    localparam int unsigned TAG_W     = 2;
    localparam int unsigned ADDR_LSB  = 0;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned LEN_LSB   = 32;
    localparam int unsigned LEN_W     = 4;
    localparam int unsigned SIZE_LSB  = 36;
    localparam int unsigned SIZE_W    = 3;
    localparam int unsigned BURST_LSB = 39;
    localparam int unsigned BURST_W   = 2;
    localparam int unsigned ID_LSB    = 41;
    localparam int unsigned RESP_W    = 2;
    localparam int unsigned HDR_W     = 41;

    // Header payload bits [40:0]; first member lands in the MSBs.
    typedef struct packed {
        logic [BURST_W-1:0] burst;
        logic [SIZE_W-1:0]  size;
        logic [LEN_W-1:0]   len;
        logic [ADDR_W-1:0]  addr;
    } axi_hdr_t;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_AR,
        S_RHDR,
        S_RDAT,
        S_AW,
        S_WDAT,
        S_BRSP
    } state_t;

endpackage

// File: rtl/spartan2axi.sv
// Spartan-bus slave endpoint: turns request/write-data words into one AXI3 burst at a time
// and returns the B/R results as Spartan response words.
module spartan2axi
    import spartan_pkg::*;
#(
    parameter int unsigned ID_WIDTH = 5,
    parameter int unsigned BWIDTH   = 64
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic [BWIDTH+1:0]     SpMBUS,
    input  logic                  SpMVLD,
    output logic                  SpMRDY,
    output logic [BWIDTH+1:0]     SpSBUS,
    output logic                  SpSVLD,
    input  logic                  SpSRDY,
    output logic [ID_WIDTH-1:0]   AWID,
    output logic [31:0]           AWADDR,
    output logic [3:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic [1:0]            AWBURST,
    output logic [1:0]            AWLOCK,
    output logic [3:0]            AWCACHE,
    output logic [2:0]            AWPROT,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [ID_WIDTH-1:0]   WID,
    output logic [BWIDTH-1:0]     WDATA,
    output logic [BWIDTH/8-1:0]   WSTRB,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [ID_WIDTH-1:0]   BID,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ID_WIDTH-1:0]   ARID,
    output logic [31:0]           ARADDR,
    output logic [3:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic [1:0]            ARBURST,
    output logic [1:0]            ARLOCK,
    output logic [3:0]            ARCACHE,
    output logic [2:0]            ARPROT,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [ID_WIDTH-1:0]   RID,
    input  logic [BWIDTH-1:0]     RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY,
    output logic                  ERR
);

    localparam int unsigned STRB_W = BWIDTH / 8;
    localparam int unsigned TAG_HI = BWIDTH + 1;

    state_t              state, state_nxt;
    logic [LEN_W-1:0]    cnt, cnt_nxt;
    logic                err, err_nxt;
    logic                cap_rd, cap_wr;
    axi_hdr_t            hdr;
    logic [ID_WIDTH-1:0] hdr_id;
    logic [STRB_W-1:0]   hdr_strb;
    logic [1:0]          spm_tag;
    logic                last_beat;

    assign spm_tag   = SpMBUS[TAG_HI -: TAG_W];
    assign last_beat = (cnt == hdr.len);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) state <= S_INIT;
        else       state <= state_nxt;
    end

    // Header capture, beat counter and sticky protocol-error flag.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cnt      <= '0;
            err      <= 1'b0;
            hdr      <= '0;
            hdr_id   <= '0;
            hdr_strb <= '0;
        end else begin
            cnt <= cnt_nxt;
            err <= err_nxt;
            if (cap_rd || cap_wr) begin
                hdr    <= axi_hdr_t'(SpMBUS[HDR_W-1:0]);
                hdr_id <= SpMBUS[ID_LSB +: ID_WIDTH];
            end
            if (cap_wr) hdr_strb <= SpMBUS[BWIDTH-1 -: STRB_W];
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = err;
        cap_rd    = 1'b0;
        cap_wr    = 1'b0;
        SpMRDY    = 1'b0;
        SpSVLD    = 1'b0;
        SpSBUS    = '0;
        ARVALID   = 1'b0;
        AWVALID   = 1'b0;
        WVALID    = 1'b0;
        WLAST     = 1'b0;
        RREADY    = 1'b0;
        BREADY    = 1'b0;
        unique case (state)
            S_INIT: state_nxt = S_IDLE;
            S_IDLE: begin
                SpMRDY = 1'b1;
                if (SpMVLD) begin
                    if (spm_tag == REQ_RD) begin
                        cap_rd    = 1'b1;
                        state_nxt = S_AR;
                    end else if (spm_tag == REQ_WR) begin
                        cap_wr    = 1'b1;
                        state_nxt = S_AW;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            S_AR: begin
                ARVALID = 1'b1;
                if (ARREADY) state_nxt = S_RHDR;
            end
            S_RHDR: begin
                SpSVLD                      = RVALID;
                SpSBUS[TAG_HI -: TAG_W]     = RSP_RDHDR;
                SpSBUS[ID_LSB +: ID_WIDTH]  = RID;
                SpSBUS[RESP_W-1:0]          = RRESP;
                if (RVALID && SpSRDY) state_nxt = S_RDAT;
            end
            S_RDAT: begin
                SpSVLD = RVALID;
                SpSBUS = {1'b1, RLAST, RDATA};
                RREADY = SpSRDY;
                if (RVALID && SpSRDY && RLAST) state_nxt = S_IDLE;
            end
            S_AW: begin
                AWVALID = 1'b1;
                if (AWREADY) state_nxt = S_WDAT;
            end
            S_WDAT: begin
                WLAST = last_beat;
                if (spm_tag[1]) begin
                    WVALID = SpMVLD;
                    SpMRDY = WREADY;
                    if (SpMVLD && WREADY) begin
                        cnt_nxt = cnt + LEN_W'(1);
                        if (spm_tag[0] != last_beat) err_nxt = 1'b1;
                        if (last_beat) begin
                            cnt_nxt   = '0;
                            state_nxt = S_BRSP;
                        end
                    end
                end else begin
                    // A header arriving mid-burst is swallowed and flagged.
                    SpMRDY = 1'b1;
                    if (SpMVLD) err_nxt = 1'b1;
                end
            end
            S_BRSP: begin
                SpSVLD                      = BVALID;
                SpSBUS[TAG_HI -: TAG_W]     = RSP_WR;
                SpSBUS[ID_LSB +: ID_WIDTH]  = BID;
                SpSBUS[RESP_W-1:0]          = BRESP;
                BREADY                      = SpSRDY;
                if (BVALID && SpSRDY) state_nxt = S_IDLE;
            end
            default: state_nxt = S_INIT;
        endcase
    end

    assign AWID    = hdr_id;
    assign AWADDR  = hdr.addr;
    assign AWLEN   = hdr.len;
    assign AWSIZE  = hdr.size;
    assign AWBURST = hdr.burst;
    assign AWLOCK  = 2'b00;
    assign AWCACHE = 4'b0000;
    assign AWPROT  = 3'b000;
    assign ARID    = hdr_id;
    assign ARADDR  = hdr.addr;
    assign ARLEN   = hdr.len;
    assign ARSIZE  = hdr.size;
    assign ARBURST = hdr.burst;
    assign ARLOCK  = 2'b00;
    assign ARCACHE = 4'b0000;
    assign ARPROT  = 3'b000;
    assign WID     = hdr_id;
    assign WDATA   = SpMBUS[BWIDTH-1:0];
    assign WSTRB   = hdr_strb;
    assign ERR     = err;

endmodule

// File: tb/tb_spartan2axi.sv
// Bench for spartan2axi: transaction-level model of Spartan words vs AXI bursts with random readiness.
module tb_spartan2axi;

    localparam int unsigned IDW = 5;
    localparam int unsigned BW  = 64;
    localparam int unsigned SW  = BW + 2;
    localparam int unsigned SBW = BW / 8;

    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    logic [SW-1:0]  SpMBUS = '0;
    logic           SpMVLD = 1'b0;
    logic           SpMRDY;
    logic [SW-1:0]  SpSBUS;
    logic           SpSVLD;
    logic           SpSRDY = 1'b0;
    logic [IDW-1:0] AWID, ARID, WID;
    logic [31:0]    AWADDR, ARADDR;
    logic [3:0]     AWLEN, ARLEN, AWCACHE, ARCACHE;
    logic [2:0]     AWSIZE, ARSIZE, AWPROT, ARPROT;
    logic [1:0]     AWBURST, ARBURST, AWLOCK, ARLOCK;
    logic           AWVALID, ARVALID, WVALID, WLAST, BREADY, RREADY, ERR;
    logic           AWREADY = 1'b0, ARREADY = 1'b0, WREADY = 1'b0;
    logic [BW-1:0]  WDATA;
    logic [SBW-1:0] WSTRB;
    logic [IDW-1:0] BID = '0, RID = '0;
    logic [1:0]     BRESP = '0, RRESP = '0;
    logic           BVALID = 1'b0, RVALID = 1'b0, RLAST = 1'b0;
    logic [BW-1:0]  RDATA = '0;

    spartan2axi #(.ID_WIDTH(IDW), .BWIDTH(BW)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .SpMBUS(SpMBUS), .SpMVLD(SpMVLD), .SpMRDY(SpMRDY),
        .SpSBUS(SpSBUS), .SpSVLD(SpSVLD), .SpSRDY(SpSRDY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .ERR(ERR)
    );

    initial forever #5 CLK = ~CLK;

    typedef struct {
        logic [IDW-1:0] id;
        logic [31:0]    addr;
        logic [3:0]     len;
        logic [2:0]     size;
        logic [1:0]     burst;
    } areq_t;
    typedef struct {
        logic [IDW-1:0] id;
        logic [BW-1:0]  data;
        logic [1:0]     resp;
        logic           last;
    } rbeat_t;
    typedef struct {
        logic [BW-1:0]  data;
        logic [SBW-1:0] strb;
        logic           last;
        logic [IDW-1:0] id;
    } wbeat_t;
    typedef struct {
        logic [IDW-1:0] id;
        logic [1:0]     resp;
    } bresp_t;

    logic [SW-1:0] spm_q[$];
    logic [SW-1:0] sps_exp_q[$];
    areq_t         ar_exp_q[$];
    areq_t         aw_exp_q[$];
    rbeat_t        r_pend[$];
    rbeat_t        r_src[$];
    wbeat_t        w_exp_q[$];
    bresp_t        b_pend[$];
    bresp_t        b_src[$];

    int checks = 0;
    int errors = 0;
    int rdy_pct = 100;
    int hold_rdat = 0;
    int sps_cnt = 0;
    bit w_toggle = 1'b0;
    bit err_exp = 1'b0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [SW-1:0] hdr_word(input logic [1:0] tag, input areq_t a,
                                               input logic [SBW-1:0] strb);
        logic [SW-1:0] w;
        w = '0;
        w[SW-1 -: 2]   = tag;
        w[31:0]        = a.addr;
        w[35:32]       = a.len;
        w[38:36]       = a.size;
        w[40:39]       = a.burst;
        w[41 +: IDW]   = a.id;
        w[BW-1 -: SBW] = strb;
        return w;
    endfunction

    function automatic logic [SW-1:0] rsp_word(input logic [1:0] tag, input logic [IDW-1:0] id,
                                               input logic [1:0] resp);
        logic [SW-1:0] w;
        w = '0;
        w[SW-1 -: 2] = tag;
        w[41 +: IDW] = id;
        w[1:0]       = resp;
        return w;
    endfunction

    function automatic bit busy();
        return (spm_q.size() + sps_exp_q.size() + ar_exp_q.size() + aw_exp_q.size() +
                r_pend.size() + r_src.size() + w_exp_q.size() + b_pend.size() + b_src.size()) != 0;
    endfunction

    function automatic areq_t rand_req();
        areq_t a;
        a.id    = IDW'($urandom);
        a.addr  = $urandom;
        a.len   = 4'($urandom);
        a.size  = 3'($urandom);
        a.burst = 2'($urandom);
        return a;
    endfunction

    // Read: one header word out, then a response header and one data word per beat back.
    task automatic queue_read(input areq_t a, input logic [IDW-1:0] rid, input logic [1:0] resp0);
        rbeat_t b;
        spm_q.push_back(hdr_word(2'b00, a, '0));
        ar_exp_q.push_back(a);
        for (int i = 0; i <= int'(a.len); i++) begin
            b.id   = rid;
            b.data = {$urandom, $urandom};
            b.resp = (i == 0) ? resp0 : 2'($urandom);
            b.last = (i == int'(a.len));
            r_pend.push_back(b);
            if (i == 0) sps_exp_q.push_back(rsp_word(2'b01, rid, resp0));
            sps_exp_q.push_back({1'b1, b.last, b.data});
        end
    endtask

    // Write: WLAST follows the header LEN; bad_idx marks a beat whose SpM last-tag is inverted.
    task automatic queue_write(input areq_t a, input logic [SBW-1:0] strb, input logic [IDW-1:0] bid,
                               input logic [1:0] bresp, input int bad_idx);
        wbeat_t w;
        bresp_t b;
        logic   tagl;
        spm_q.push_back(hdr_word(2'b01, a, strb));
        aw_exp_q.push_back(a);
        for (int i = 0; i <= int'(a.len); i++) begin
            w.data = {$urandom, $urandom};
            w.strb = strb;
            w.last = (i == int'(a.len));
            w.id   = a.id;
            tagl   = w.last;
            if (i == bad_idx) begin
                tagl    = ~tagl;
                err_exp = 1'b1;
            end
            spm_q.push_back({1'b1, tagl, w.data});
            w_exp_q.push_back(w);
        end
        b.id   = bid;
        b.resp = bresp;
        b_pend.push_back(b);
        sps_exp_q.push_back(rsp_word(2'b00, bid, bresp));
    endtask

    // One clock of all bench agents: drive at negedge, sample, score handshakes due at the posedge.
    task automatic cycle();
        bit     held;
        areq_t  a;
        wbeat_t w;
        @(negedge CLK);
        SpMVLD  = (spm_q.size() > 0) && ($urandom_range(99) < 85);
        SpMBUS  = (spm_q.size() > 0) ? spm_q[0] : '0;
        ARREADY = ($urandom_range(99) < rdy_pct);
        AWREADY = ($urandom_range(99) < rdy_pct);
        WREADY  = w_toggle ? ~WREADY : ($urandom_range(99) < rdy_pct);
        RVALID  = (r_src.size() > 0);
        if (RVALID) begin
            RID = r_src[0].id; RDATA = r_src[0].data; RRESP = r_src[0].resp; RLAST = r_src[0].last;
        end else begin
            RID = '0; RDATA = '0; RRESP = '0; RLAST = 1'b0;
        end
        BVALID = (b_src.size() > 0);
        BID    = BVALID ? b_src[0].id : '0;
        BRESP  = BVALID ? b_src[0].resp : '0;
        #1;
        held = 1'b0;
        if (hold_rdat > 0 && SpSVLD && SpSBUS[SW-1]) begin
            SpSRDY = 1'b0;
            hold_rdat--;
            held = 1'b1;
        end else begin
            SpSRDY = ($urandom_range(99) < rdy_pct);
        end
        #1;
        if (held) chk("rready_hold", 128'(RREADY), 128'(0));
        if (SpSVLD && SpSBUS[SW-1]) chk("rready_track", 128'(RREADY), 128'(SpSRDY));
        if (WVALID) begin
            chk("w_before_aw", 128'(aw_exp_q.size() != 0), 128'(0));
            chk("spmrdy_track", 128'(SpMRDY), 128'(WREADY));
        end
        if (SpMVLD && SpMRDY) void'(spm_q.pop_front());
        if (ARVALID && ARREADY) begin
            if (ar_exp_q.size() == 0) chk("ar_unexpected", 128'(1), 128'(0));
            else begin
                a = ar_exp_q.pop_front();
                chk("ar_fields", 128'({ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT}),
                    128'({a.id, a.addr, a.len, a.size, a.burst, 2'b00, 4'b0000, 3'b000}));
                while (r_pend.size() > 0) r_src.push_back(r_pend.pop_front());
            end
        end
        if (AWVALID && AWREADY) begin
            if (aw_exp_q.size() == 0) chk("aw_unexpected", 128'(1), 128'(0));
            else begin
                a = aw_exp_q.pop_front();
                chk("aw_fields", 128'({AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT}),
                    128'({a.id, a.addr, a.len, a.size, a.burst, 2'b00, 4'b0000, 3'b000}));
            end
        end
        if (WVALID && WREADY) begin
            if (w_exp_q.size() == 0) chk("w_unexpected", 128'(1), 128'(0));
            else begin
                w = w_exp_q.pop_front();
                chk("w_beat", {WID, WSTRB, WLAST, WDATA}, {w.id, w.strb, w.last, w.data});
                if (w.last) while (b_pend.size() > 0) b_src.push_back(b_pend.pop_front());
            end
        end
        if (RVALID && RREADY) void'(r_src.pop_front());
        if (BVALID && BREADY) void'(b_src.pop_front());
        if (SpSVLD && SpSRDY) begin
            sps_cnt++;
            if (sps_exp_q.size() == 0) chk("sps_unexpected", 128'(SpSBUS), 128'(0));
            else chk("sps_word", 128'(SpSBUS), 128'(sps_exp_q.pop_front()));
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (busy() && n < 3000) begin
            cycle();
            n++;
        end
        chk({tag, "_timeout"}, 128'(n >= 3000), 128'(0));
        cycle();
        cycle();
        chk({tag, "_err"}, 128'(ERR), 128'(err_exp));
    endtask

    task automatic rand_txns(input int n);
        areq_t          a;
        logic [IDW-1:0] rid;
        for (int i = 0; i < n; i++) begin
            a   = rand_req();
            rid = ($urandom_range(9) < 3) ? IDW'($urandom) : a.id;
            if ($urandom_range(1) == 0) queue_read(a, rid, 2'($urandom));
            else queue_write(a, SBW'($urandom), rid, 2'($urandom), -1);
            wait_done("rand");
        end
    endtask

    initial begin
        areq_t a;
        int    n;

        // Reset state
        #1;
        chk("rst_valids", 128'({ARVALID, AWVALID, WVALID, RREADY, BREADY, SpMRDY, SpSVLD}), 128'(0));
        chk("rst_err", 128'(ERR), 128'(0));
        chk("rst_regs", 128'({ARADDR, ARLEN, ARID, WSTRB}), 128'(0));
        @(negedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
        #1;
        chk("init_spmrdy", 128'(SpMRDY), 128'(0));
        @(negedge CLK);
        #1;
        chk("idle_spmrdy", 128'(SpMRDY), 128'(1));

        // Directed read: ADDR 0x1000, LEN 3, ID 5
        a = '{id: 5'd5, addr: 32'h1000, len: 4'd3, size: 3'd3, burst: 2'd1};
        queue_read(a, 5'd5, 2'b00);
        wait_done("t1_read");

        // Directed write: ADDR 0x2000, LEN 1, STRB 0x0F, BRESP 10
        a = '{id: 5'd9, addr: 32'h2000, len: 4'd1, size: 3'd3, burst: 2'd1};
        queue_write(a, 8'h0F, 5'd9, 2'b10, -1);
        wait_done("t2_write");

        // Backpressure: SpSRDY held low in RDAT, WREADY toggling
        hold_rdat = 4;
        a = '{id: 5'd3, addr: 32'h3000, len: 4'd7, size: 3'd3, burst: 2'd1};
        queue_read(a, 5'd3, 2'b01);
        wait_done("t3_read");
        chk("t3_hold_used", 128'(hold_rdat), 128'(0));
        w_toggle = 1'b1;
        a = '{id: 5'd4, addr: 32'h4000, len: 4'd15, size: 3'd3, burst: 2'd1};
        queue_write(a, 8'hA5, 5'd4, 2'b00, -1);
        wait_done("t3_write");
        w_toggle = 1'b0;

        rdy_pct = 60;
        rand_txns(8);

        // Stray data word while idle
        spm_q.push_back({2'b10, 32'($urandom), 32'($urandom)});
        err_exp = 1'b1;
        wait_done("t5_stray");

        // Reset in the middle of a read burst
        rdy_pct = 100;
        a = '{id: 5'd7, addr: 32'h5000, len: 4'd7, size: 3'd3, burst: 2'd1};
        queue_read(a, 5'd7, 2'b00);
        sps_cnt = 0;
        n = 0;
        while (sps_cnt < 3 && n < 500) begin
            cycle();
            n++;
        end
        chk("t6_reach_timeout", 128'(n >= 500), 128'(0));
        @(posedge CLK);
        #2;
        RSTN = 1'b0;
        #1;
        chk("t6_rst_valids", 128'({ARVALID, AWVALID, WVALID, RREADY, BREADY, SpMRDY, SpSVLD}), 128'(0));
        chk("t6_rst_err", 128'(ERR), 128'(0));
        spm_q.delete(); sps_exp_q.delete(); ar_exp_q.delete(); aw_exp_q.delete();
        r_pend.delete(); r_src.delete(); w_exp_q.delete(); b_pend.delete(); b_src.delete();
        err_exp = 1'b0;
        SpMVLD = 1'b0; RVALID = 1'b0; BVALID = 1'b0; SpSRDY = 1'b0;
        repeat (3) @(negedge CLK);
        RSTN = 1'b1;
        a = '{id: 5'd12, addr: 32'h6000, len: 4'd2, size: 3'd2, burst: 2'd0};
        queue_write(a, 8'hFF, 5'd12, 2'b00, -1);
        wait_done("t6_write");

        // Early last-tag on beat 2 of a 3-beat write
        rdy_pct = 60;
        a = '{id: 5'd20, addr: 32'h7000, len: 4'd2, size: 3'd3, burst: 2'd1};
        queue_write(a, 8'h3C, 5'd20, 2'b01, 1);
        wait_done("t4_badlast");

        rand_txns(8);
        chk("final_err_sticky", 128'(ERR), 128'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
